// File: rtl/rgb2gray_pkg.sv
// Shared constants, pixel type and pixel-slice helper for the 4-pixel-per-clock video path.
package rgb2gray_pkg;

    localparam int PPC    = 4;
    localparam int PIX_W  = 24;
    localparam int BEAT_W = PPC * PIX_W;

    localparam logic [7:0]  COEF_R = 8'd77;
    localparam logic [7:0]  COEF_G = 8'd150;
    localparam logic [7:0]  COEF_B = 8'd29;
    localparam logic [15:0] ROUND  = 16'd128;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Pixel 0 occupies the most significant 24 bits of the beat.
    function automatic rgb_t get_pixel(input logic [BEAT_W-1:0] beat, input int k);
        return beat[BEAT_W-1-PIX_W*k -: PIX_W];
    endfunction

endpackage

// File: rtl/rgb2gray_4ppc_axis_if.sv
// AXI4-Stream video beat bundle (4 RGB pixels plus start-of-frame and end-of-line).
interface rgb2gray_4ppc_axis_if;
    import rgb2gray_pkg::*;

    logic [BEAT_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/sync_fifo_reg.sv
// Synchronous FIFO with a registered head word and an occupancy count; any depth >= 2.
module sync_fifo_reg #(
    parameter int WIDTH = 98,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_next;
    logic [PTR_W-1:0] rd_next;
    logic             push_en;
    logic             pop_en;

    assign head_valid = (count != '0);
    assign pop_en     = pop && head_valid;
    assign push_en    = push && ((count != CNT_W'(DEPTH)) || pop_en);

    // Explicit wrap so the depth does not have to be a power of two.
    assign wr_next = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    assign rd_next = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_data <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_next;
            end
            if (pop_en) begin
                rd_ptr <= rd_next;
            end
            if (push_en && !pop_en) begin
                count <= count + CNT_W'(1);
            end else if (pop_en && !push_en) begin
                count <= count - CNT_W'(1);
            end
            // Head tracks mem[rd_ptr]; a push into an empty (or emptying) FIFO bypasses memory.
            if (pop_en) begin
                if (count > CNT_W'(1)) begin
                    head_data <= mem[rd_next];
                end else if (push_en) begin
                    head_data <= push_data;
                end
            end else if (push_en && !head_valid) begin
                head_data <= push_data;
            end
        end
    end

endmodule

// File: rtl/rgb2gray_4ppc_axis.sv
// RGB to grayscale for 4 pixels per clock: 3-stage luma pipeline, output FIFO, credit-based tready.
module rgb2gray_4ppc_axis
    import rgb2gray_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        s_axis_video_aclk,
    input  logic                        rst,
    rgb2gray_4ppc_axis_if.slave         VIDEO_IN,
    rgb2gray_4ppc_axis_if.master        VIDEO_OUT
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;
    localparam int FIFO_W = BEAT_W + 2;

    logic                         in_fire;
    rgb_t                         px;
    logic [PPC-1:0][2:0][15:0]    prod;
    logic [PPC-1:0][2:0][15:0]    s1_prod;
    logic [PPC-1:0][15:0]         s2_sum;
    logic [BEAT_W-1:0]            s3_data;
    logic                         s1_valid, s2_valid, s3_valid;
    logic                         s1_user, s2_user, s3_user;
    logic                         s1_last, s2_last, s3_last;
    logic [1:0]                   inflight;
    logic [CNT_W-1:0]             fifo_count;
    logic [FIFO_W-1:0]            head;

    // Every beat in the pipeline already owns a FIFO slot, so the FIFO can never overflow.
    assign inflight       = 2'(s1_valid) + 2'(s2_valid) + 2'(s3_valid);
    assign VIDEO_IN.tready = !rst &&
        ((SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH));
    assign in_fire        = VIDEO_IN.tvalid && VIDEO_IN.tready;

    always_comb begin
        px   = '0;
        prod = '0;
        for (int k = 0; k < PPC; k++) begin
            px         = get_pixel(VIDEO_IN.tdata, k);
            prod[k][0] = 16'(COEF_R) * 16'(px.r);
            prod[k][1] = 16'(COEF_G) * 16'(px.g);
            prod[k][2] = 16'(COEF_B) * 16'(px.b);
        end
    end

    always_ff @(posedge s_axis_video_aclk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= in_fire;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
        end
    end

    // Data and sideband advance every clock; only the valid bits need reset.
    always_ff @(posedge s_axis_video_aclk) begin
        s1_prod <= prod;
        s1_user <= VIDEO_IN.tuser;
        s1_last <= VIDEO_IN.tlast;
        for (int k = 0; k < PPC; k++) begin
            s2_sum[k] <= s1_prod[k][0] + s1_prod[k][1] + s1_prod[k][2] + ROUND;
        end
        s2_user <= s1_user;
        s2_last <= s1_last;
        for (int k = 0; k < PPC; k++) begin
            s3_data[BEAT_W-1-PIX_W*k -: PIX_W] <= {3{s2_sum[k][15:8]}};
        end
        s3_user <= s2_user;
        s3_last <= s2_last;
    end

    sync_fifo_reg #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (s_axis_video_aclk),
        .rst        (rst),
        .push       (s3_valid),
        .push_data  ({s3_data, s3_user, s3_last}),
        .pop        (VIDEO_OUT.tready),
        .head_data  (head),
        .head_valid (VIDEO_OUT.tvalid),
        .count      (fifo_count)
    );

    assign VIDEO_OUT.tdata = head[FIFO_W-1:2];
    assign VIDEO_OUT.tuser = head[1];
    assign VIDEO_OUT.tlast = head[0];

endmodule

// File: tb/tb_rgb2gray_4ppc_axis.sv
// Self-checking bench for rgb2gray_4ppc_axis: vector table, scoreboard monitor and corner-case sequences.
module tb_rgb2gray_4ppc_axis;

    localparam int FIFO_DEPTH = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cyc;
    int   acc_cnt;
    int   pop_cnt;
    int   last_acc_cyc;
    int   last_pop_cyc;
    logic done;

    logic [97:0] sb[$];
    logic        stalled;
    logic [97:0] held;

    typedef struct {
        logic [95:0] din;
        logic        user;
        logic        last;
        logic [95:0] dout;
    } vec_t;

    vec_t vecs[3];

    rgb2gray_4ppc_axis_if video_in ();
    rgb2gray_4ppc_axis_if video_out ();

    rgb2gray_4ppc_axis #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .s_axis_video_aclk (clk),
        .rst               (rst),
        .VIDEO_IN          (video_in),
        .VIDEO_OUT         (video_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference luma: Y = (77R + 150G + 29B + 128) >> 8, replicated to R, G and B.
    function automatic logic [95:0] luma_model(input logic [95:0] d);
        logic [95:0] r;
        int rr, gg, bb, y;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            rr = int'(d[95-24*k -: 8]);
            gg = int'(d[87-24*k -: 8]);
            bb = int'(d[79-24*k -: 8]);
            y  = (77 * rr + 150 * gg + 29 * bb + 128) >> 8;
            r[95-24*k -: 24] = {3{y[7:0]}};
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [95:0] d, input logic u, input logic l);
        int waited;
        waited = 0;
        video_in.tdata  = d;
        video_in.tuser  = u;
        video_in.tlast  = l;
        video_in.tvalid = 1'b1;
        @(negedge clk);
        while (!video_in.tready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!video_in.tready) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got tready=0 expected 1 within 1000 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        video_in.tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        video_in.tvalid  = 1'b0;
        video_out.tready = 1'b1;
        while ((sb.size() != 0 || video_out.tvalid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    // Scoreboard monitor: samples both handshakes on the falling edge.
    always @(negedge clk) begin
        logic [97:0] act;
        logic [97:0] exp;
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            act = {video_out.tdata, video_out.tuser, video_out.tlast};
            if (stalled) begin
                total++;
                if (!video_out.tvalid || act !== held) begin
                    bad++;
                    $display("[TB] FAIL out_stable: got v=%0b %h expected v=1 %h", video_out.tvalid, act, held);
                end
            end
            if (video_out.tvalid && video_out.tready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_out: got %h expected no beat", act);
                end else begin
                    exp = sb.pop_front();
                    if (act !== exp) begin
                        bad++;
                        $display("[TB] FAIL scoreboard: got %h expected %h", act, exp);
                    end
                end
                pop_cnt++;
                last_pop_cyc = cyc;
            end
            if (video_in.tvalid && video_in.tready) begin
                sb.push_back({luma_model(video_in.tdata), video_in.tuser, video_in.tlast});
                acc_cnt++;
                last_acc_cyc = cyc;
                total++;
                if (sb.size() > FIFO_DEPTH) begin
                    bad++;
                    $display("[TB] FAIL occupancy: got %0d expected <= %0d", sb.size(), FIFO_DEPTH);
                end
            end
            stalled = video_out.tvalid && !video_out.tready;
            held    = act;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got no finish expected finish within 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int base;
        int t0;
        int first_acc;
        logic [95:0] d;
        logic        u;
        logic        l;
        logic        accepted;

        vecs[0] = '{96'hFF0000_00FF00_0000FF_FFFFFF, 1'b1, 1'b1, 96'h4D4D4D_959595_1D1D1D_FFFFFF};
        vecs[1] = '{96'h000000_000000_000000_000000, 1'b0, 1'b0, 96'h000000_000000_000000_000000};
        vecs[2] = '{96'h808080_6432C8_010101_000000, 1'b0, 1'b1, 96'h808080_525252_010101_000000};

        total = 0; bad = 0; cyc = 0; acc_cnt = 0; pop_cnt = 0;
        last_acc_cyc = 0; last_pop_cyc = 0; done = 1'b0; stalled = 1'b0; held = '0;
        rst = 1'b1;
        video_in.tdata = '0; video_in.tvalid = 1'b0; video_in.tuser = 1'b0; video_in.tlast = 1'b0;
        video_out.tready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_tready", 128'(video_in.tready), 128'(0));
        checkOutput("rst_out_tvalid", 128'(video_out.tvalid), 128'(0));
        checkOutput("rst_out_tdata", 128'(video_out.tdata), 128'(0));
        checkOutput("rst_out_tuser", 128'(video_out.tuser), 128'(0));
        checkOutput("rst_out_tlast", 128'(video_out.tlast), 128'(0));
        rst = 1'b0;
        #1;
        checkOutput("post_rst_tready", 128'(video_in.tready), 128'(1));
        @(posedge clk);
        #1;

        // Table vectors with exact latency
        video_out.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].din, vecs[i].user, vecs[i].last);
            video_in.tvalid = 1'b0;
            lat = 0;
            while (!video_out.tvalid && lat < 10) begin
                @(posedge clk);
                #1;
                lat++;
            end
            checkOutput($sformatf("latency_%0d", i), 128'(lat), 128'(3));
            checkOutput($sformatf("vector_%0d", i),
                        128'({video_out.tdata, video_out.tuser, video_out.tlast}),
                        128'({vecs[i].dout, vecs[i].user, vecs[i].last}));
            idleCycles(3);
        end

        // Full-rate 64x64 frame
        base = pop_cnt;
        t0   = cyc;
        first_acc = 0;
        for (int line = 0; line < 64; line++) begin
            for (int b = 0; b < 16; b++) begin
                applyStimulus({$urandom, $urandom, $urandom}, (line == 0 && b == 0), (b == 15));
                if (line == 0 && b == 0) first_acc = last_acc_cyc;
            end
        end
        checkOutput("frame_in_cycles", 128'(cyc - t0), 128'(1024));
        drain();
        checkOutput("frame_out_beats", 128'(pop_cnt - base), 128'(1024));
        checkOutput("frame_out_span", 128'(last_pop_cyc - first_acc), 128'(1027));
        idleCycles(2);

        // Backpressure: stream for 20 cycles with the sink stalled
        video_out.tready = 1'b0;
        base = acc_cnt;
        d = {$urandom, $urandom, $urandom};
        u = 1'b1;
        l = 1'b0;
        video_in.tvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            video_in.tdata = d;
            video_in.tuser = u;
            video_in.tlast = l;
            @(negedge clk);
            accepted = video_in.tready;
            @(posedge clk);
            #1;
            if (accepted) begin
                d = {$urandom, $urandom, $urandom};
                u = 1'b0;
                l = 1'(c % 3 == 2);
            end
        end
        checkOutput("bp_accepted", 128'(acc_cnt - base), 128'(FIFO_DEPTH));
        checkOutput("bp_tready_low", 128'(video_in.tready), 128'(0));
        video_in.tvalid  = 1'b0;
        video_out.tready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_tready_after_pop", 128'(video_in.tready), 128'(1));
        drain();
        idleCycles(2);

        // Random valid and ready on both sides
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 5000; i++) begin
                    while ($urandom_range(1) == 0) begin
                        video_in.tvalid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus({$urandom, $urandom, $urandom}, 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
                video_in.tvalid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    video_out.tready = 1'($urandom_range(1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        idleCycles(2);

        // Reset with 3 beats in the pipeline and 4 in the FIFO
        video_out.tready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            applyStimulus({$urandom, $urandom, $urandom}, (i == 0), 1'b0);
        end
        video_in.tvalid = 1'b0;
        checkOutput("mid_fifo_nonempty", 128'(video_out.tvalid), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_tready", 128'(video_in.tready), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_out_tvalid", 128'(video_out.tvalid), 128'(0));
        checkOutput("mid_rst_out_tdata", 128'(video_out.tdata), 128'(0));
        checkOutput("mid_rst_in_tready", 128'(video_in.tready), 128'(1));
        video_out.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("mid_rst_no_partial", 128'(video_out.tvalid), 128'(0));
        end
        for (int b = 0; b < 16; b++) begin
            applyStimulus({$urandom, $urandom, $urandom}, (b == 0), (b == 15));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
